// File: rtl/tcm_dec_trb_engine.sv
// Traceback engine for the 4D-8PSK TCM Viterbi decoder. It reads one decision
// RAM buffer backwards and emits the decoded bits in reverse time order.
//
// Ports:
//   iclk, ireset, iclkena      clock, async active-high reset, clock enable
//   istart, iraddr_bidx,
//   isize_m1, istate           regular traceback request and its fields
//   iflush, ifraddr_bidx,
//   ifsize_m1, ifstate         flush request and its fields
//   ordy                       engine idle, a command can be accepted
//   oread, oraddr              decision RAM read strobe and {bidx, addr}
//   irdecision                 decision word, pRAM_LAT enabled clocks after oread
//   oval, osop, oeop, oflush   decoded output strobe and command tags
//   obits, ostate              decoded bits and current traceback state
module tcm_dec_trb_engine #(
    parameter int pSTATE_W    = 6,
    parameter int pDEC_W      = 2,
    parameter int pTRB_LENGTH = 64,
    parameter int pADDR_W     = 6,
    parameter int pBIDX_W     = 2,
    parameter int pRAM_LAT    = 2
) (
    input  logic                          iclk,
    input  logic                          ireset,
    input  logic                          iclkena,
    input  logic                          istart,
    input  logic [pBIDX_W-1:0]            iraddr_bidx,
    input  logic [pADDR_W-1:0]            isize_m1,
    input  logic [pSTATE_W-1:0]           istate,
    input  logic                          iflush,
    input  logic [pBIDX_W-1:0]            ifraddr_bidx,
    input  logic [pADDR_W-1:0]            ifsize_m1,
    input  logic [pSTATE_W-1:0]           ifstate,
    output logic                          ordy,
    output logic                          oread,
    output logic [pBIDX_W+pADDR_W-1:0]    oraddr,
    input  logic [(2**pSTATE_W)*pDEC_W-1:0] irdecision,
    output logic                          oval,
    output logic                          osop,
    output logic                          oeop,
    output logic                          oflush,
    output logic [pDEC_W-1:0]             obits,
    output logic [pSTATE_W-1:0]           ostate
);

    localparam int cL     = pRAM_LAT;
    localparam int cCNT_W = $clog2(pTRB_LENGTH);

    localparam logic [1:0] cIDLE  = 2'd0;
    localparam logic [1:0] cREAD  = 2'd1;
    localparam logic [1:0] cDRAIN = 2'd2;

    // control
    logic [1:0]          state_q, state_d;
    logic                ordy_q, ordy_d;
    logic [pBIDX_W-1:0]  bidx_q, bidx_d;
    logic [cCNT_W-1:0]   cnt_q, cnt_d;
    logic                ftag_q, ftag_d;
    logic                first_q, first_d;

    // read strobe, address and the tags travelling with it
    logic                oread_q, oread_d;
    logic [pBIDX_W+pADDR_W-1:0] oraddr_q, oraddr_d;
    logic                rsop_q, rsop_d;
    logic                reop_q, reop_d;
    logic                rfl_q, rfl_d;

    // read-valid shift line, mirrors the RAM latency
    logic [cL-1:0]       pv_q, pv_d;
    logic [cL-1:0]       ps_q, ps_d;
    logic [cL-1:0]       pe_q, pe_d;
    logic [cL-1:0]       pf_q, pf_d;

    // traceback data path
    logic [pSTATE_W-1:0] cur_q, cur_d;
    logic [pDEC_W-1:0]   obits_q, obits_d;
    logic                oval_q, oval_d;
    logic                osop_q, osop_d;
    logic                oeop_q, oeop_d;
    logic                oflush_q, oflush_d;

    logic                idle;
    logic                acc_s;
    logic                acc_f;
    logic                wv;
    logic [pDEC_W-1:0]   dsel;

    assign idle  = (state_q == cIDLE);
    assign acc_s = idle & istart;
    assign acc_f = idle & ~istart & iflush;
    assign wv    = pv_q[cL-1];

    // predecessor select of the current state in the returned word
    assign dsel = irdecision[int'(cur_q)*pDEC_W +: pDEC_W];

    always_comb begin
        state_d  = state_q;
        bidx_d   = bidx_q;
        cnt_d    = cnt_q;
        ftag_d   = ftag_q;
        first_d  = first_q;
        oread_d  = 1'b0;
        oraddr_d = oraddr_q;
        rsop_d   = 1'b0;
        reop_d   = 1'b0;
        rfl_d    = 1'b0;
        unique case (state_q)
            cIDLE: begin
                if (acc_s) begin
                    bidx_d  = iraddr_bidx;
                    cnt_d   = isize_m1;
                    ftag_d  = 1'b0;
                    first_d = 1'b1;
                    state_d = cREAD;
                end else if (acc_f) begin
                    bidx_d  = ifraddr_bidx;
                    cnt_d   = ifsize_m1;
                    ftag_d  = 1'b1;
                    first_d = 1'b1;
                    state_d = cREAD;
                end
            end
            cREAD: begin
                // addresses do not depend on data: one read per clock
                oread_d  = 1'b1;
                oraddr_d = {bidx_q, cnt_q};
                rsop_d   = first_q;
                reop_d   = (cnt_q == '0);
                rfl_d    = ftag_q;
                first_d  = 1'b0;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = cDRAIN;
                end
            end
            cDRAIN: begin
                // leave as the last word is turned into the eop output
                if (wv && pe_q[cL-1]) begin
                    state_d = cIDLE;
                end
            end
            default: begin
                state_d = cIDLE;
            end
        endcase
        ordy_d = (state_d == cIDLE);
    end

    always_comb begin
        pv_d = {cL{1'b0}};
        ps_d = {cL{1'b0}};
        pe_d = {cL{1'b0}};
        pf_d = {cL{1'b0}};
        pv_d[0] = oread_q;
        ps_d[0] = rsop_q;
        pe_d[0] = reop_q;
        pf_d[0] = rfl_q;
        for (int i = 1; i < cL; i++) begin
            pv_d[i] = pv_q[i-1];
            ps_d[i] = ps_q[i-1];
            pe_d[i] = pe_q[i-1];
            pf_d[i] = pf_q[i-1];
        end
    end

    always_comb begin
        cur_d    = cur_q;
        obits_d  = obits_q;
        oval_d   = wv;
        osop_d   = wv & ps_q[cL-1];
        oeop_d   = wv & pe_q[cL-1];
        oflush_d = wv & pf_q[cL-1];
        if (acc_s) begin
            cur_d = istate;
        end else if (acc_f) begin
            cur_d = ifstate;
        end else if (wv) begin
            // decoded bits are the top of the state; shift in predecessor
            obits_d = cur_q[pSTATE_W-1 -: pDEC_W];
            cur_d   = {cur_q[pSTATE_W-pDEC_W-1:0], dsel};
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q  <= cIDLE;
            ordy_q   <= 1'b1;
            bidx_q   <= '0;
            cnt_q    <= '0;
            ftag_q   <= 1'b0;
            first_q  <= 1'b0;
            oread_q  <= 1'b0;
            oraddr_q <= '0;
            rsop_q   <= 1'b0;
            reop_q   <= 1'b0;
            rfl_q    <= 1'b0;
            pv_q     <= '0;
            ps_q     <= '0;
            pe_q     <= '0;
            pf_q     <= '0;
            cur_q    <= '0;
            obits_q  <= '0;
            oval_q   <= 1'b0;
            osop_q   <= 1'b0;
            oeop_q   <= 1'b0;
            oflush_q <= 1'b0;
        end else if (iclkena) begin
            state_q  <= state_d;
            ordy_q   <= ordy_d;
            bidx_q   <= bidx_d;
            cnt_q    <= cnt_d;
            ftag_q   <= ftag_d;
            first_q  <= first_d;
            oread_q  <= oread_d;
            oraddr_q <= oraddr_d;
            rsop_q   <= rsop_d;
            reop_q   <= reop_d;
            rfl_q    <= rfl_d;
            pv_q     <= pv_d;
            ps_q     <= ps_d;
            pe_q     <= pe_d;
            pf_q     <= pf_d;
            cur_q    <= cur_d;
            obits_q  <= obits_d;
            oval_q   <= oval_d;
            osop_q   <= osop_d;
            oeop_q   <= oeop_d;
            oflush_q <= oflush_d;
        end
    end

    assign ordy   = ordy_q;
    assign oread  = oread_q;
    assign oraddr = oraddr_q;
    assign oval   = oval_q;
    assign osop   = osop_q;
    assign oeop   = oeop_q;
    assign oflush = oflush_q;
    assign obits  = obits_q;
    assign ostate = cur_q;

endmodule

// File: tb/tb_tcm_dec_trb_engine.sv
// Bench for tcm_dec_trb_engine: random and directed commands, a decision
// RAM model and a scoreboard fed by a traceback reference model.
module tb_tcm_dec_trb_engine;

    localparam int LAT = 2;

    logic         iclk;
    logic         ireset;
    logic         iclkena;
    logic         istart;
    logic [1:0]   iraddr_bidx;
    logic [5:0]   isize_m1;
    logic [5:0]   istate;
    logic         iflush;
    logic [1:0]   ifraddr_bidx;
    logic [5:0]   ifsize_m1;
    logic [5:0]   ifstate;
    logic         ordy;
    logic         oread;
    logic [7:0]   oraddr;
    logic [127:0] irdecision;
    logic         oval;
    logic         osop;
    logic         oeop;
    logic         oflush;
    logic [1:0]   obits;
    logic [5:0]   ostate;

    tcm_dec_trb_engine #(
        .pSTATE_W(6), .pDEC_W(2), .pTRB_LENGTH(64),
        .pADDR_W(6), .pBIDX_W(2), .pRAM_LAT(LAT)
    ) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .istart(istart), .iraddr_bidx(iraddr_bidx),
        .isize_m1(isize_m1), .istate(istate),
        .iflush(iflush), .ifraddr_bidx(ifraddr_bidx),
        .ifsize_m1(ifsize_m1), .ifstate(ifstate),
        .ordy(ordy), .oread(oread), .oraddr(oraddr),
        .irdecision(irdecision),
        .oval(oval), .osop(osop), .oeop(oeop), .oflush(oflush),
        .obits(obits), .ostate(ostate)
    );

    typedef struct {
        logic [1:0] bits;
        bit         sop;
        bit         eop;
        bit         fl;
        logic [5:0] st;
    } exp_t;

    exp_t         exp_q[$];
    logic [7:0]   addr_q[$];
    int           busy_q[$];
    int           busy_cnt;
    int           checks;
    int           failures;
    bit           toggle_en;

    logic [127:0] mem [256];
    logic [7:0]   rp [LAT];

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // decision RAM: address pipeline of LAT enabled clocks
    always @(posedge iclk) begin
        if (iclkena) begin
            rp[0] <= oraddr;
            for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
        end
    end
    assign irdecision = mem[rp[LAT-1]];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // clock enable: always on, or random 50% while toggle_en is set
    initial begin
        forever begin
            @(posedge iclk);
            #3;
            iclkena = toggle_en ? 1'($urandom % 2) : 1'b1;
        end
    end

    // monitor: one look per enabled edge
    initial begin
        bit   en;
        bit   rs;
        exp_t e;
        logic [7:0] a;
        forever begin
            @(posedge iclk);
            en = iclkena;
            rs = ireset;
            #1;
            if (ireset || rs) begin
                busy_cnt = 0;
            end else if (en) begin
                if (oread) begin
                    if (addr_q.size() == 0) begin
                        chk("stray_oread", 1, 0);
                    end else begin
                        a = addr_q.pop_front();
                        chk("oraddr", 32'(oraddr), 32'(a));
                    end
                end
                if (oval) begin
                    if (exp_q.size() == 0) begin
                        chk("stray_oval", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("obits", 32'(obits), 32'(e.bits));
                        chk("osop", 32'(osop), 32'(e.sop));
                        chk("oeop", 32'(oeop), 32'(e.eop));
                        chk("oflush", 32'(oflush), 32'(e.fl));
                        chk("ostate", 32'(ostate), 32'(e.st));
                    end
                end
                if (!ordy) begin
                    busy_cnt++;
                end else if (busy_cnt > 0) begin
                    if (busy_q.size() == 0) begin
                        chk("stray_busy", 32'(busy_cnt), 0);
                    end else begin
                        chk("busy_clocks", 32'(busy_cnt),
                            32'(busy_q.pop_front()));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // reference: walk the buffer backwards following predecessor selects
    task automatic push_cmd(input int bidx, input int s, input int st0,
                            input bit fl);
        int   st;
        int   a;
        int   d;
        exp_t e;
        st = st0;
        for (int k = 0; k <= s; k++) begin
            a = bidx * 64 + (s - k);
            addr_q.push_back(8'(a));
            e.bits = 2'(st / 16);
            d = int'((mem[a] >> (2 * st)) & 128'd3);
            st = (st * 4 + d) % 64;
            e.st  = 6'(st);
            e.sop = (k == 0);
            e.eop = (k == s);
            e.fl  = fl;
            exp_q.push_back(e);
        end
        busy_q.push_back(s + 2 + LAT);
    endtask

    task automatic fill_const(input logic [1:0] v);
        for (int i = 0; i < 256; i++) mem[i] = {64{v}};
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) begin
            mem[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // called at a negedge; returns at the accepting posedge
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            #4;
            if (ordy && iclkena) begin
                @(posedge iclk);
                ok = 1'b1;
                break;
            end
            @(negedge iclk);
        end
        if (!ok) chk("accept_timeout", 1, 0);
    endtask

    task automatic run_cmd(input bit fl, input int bidx, input int s,
                           input int st);
        bit ok;
        @(negedge iclk);
        if (fl) begin
            iflush       = 1'b1;
            ifraddr_bidx = 2'(bidx);
            ifsize_m1    = 6'(s);
            ifstate      = 6'(st);
        end else begin
            istart      = 1'b1;
            iraddr_bidx = 2'(bidx);
            isize_m1    = 6'(s);
            istate      = 6'(st);
        end
        wait_accept(ok);
        if (ok) push_cmd(bidx, s, st, fl);
        @(negedge iclk);
        istart = 1'b0;
        iflush = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge iclk);
            if (exp_q.size() == 0 && addr_q.size() == 0 &&
                busy_q.size() == 0 && ordy) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", 32'(done), 1);
    endtask

    initial begin
        bit ok;
        int sb;
        int ss;
        int fb;
        int fs;
        int fst;
        int sst;
        checks = 0;
        failures = 0;
        busy_cnt = 0;
        toggle_en = 1'b0;
        ireset = 1'b1;
        iclkena = 1'b1;
        istart = 1'b0;
        iflush = 1'b0;
        iraddr_bidx = '0;
        isize_m1 = '0;
        istate = '0;
        ifraddr_bidx = '0;
        ifsize_m1 = '0;
        ifstate = '0;
        for (int i = 0; i < LAT; i++) rp[i] = '0;
        fill_const(2'b00);
        #3;
        chk("rst_ordy", 32'(ordy), 1);
        chk("rst_oread", 32'(oread), 0);
        chk("rst_oval", 32'(oval), 0);
        chk("rst_oraddr", 32'(oraddr), 0);
        chk("rst_obits", 32'(obits), 0);
        chk("rst_ostate", 32'(ostate), 0);
        repeat (3) @(negedge iclk);
        ireset = 1'b0;

        // all-zero decisions, full buffer
        run_cmd(1'b0, 1, 63, 0);
        wait_idle();

        // all-ones decisions from 0x2A
        fill_const(2'b11);
        run_cmd(1'b0, 2, 9, 6'h2A);
        wait_idle();

        // flush from 0x3F with zero decisions
        fill_const(2'b00);
        run_cmd(1'b1, 3, 5, 6'h3F);
        wait_idle();

        // start and flush together: start first, flush right after
        fill_rand();
        sb = 0; ss = 12; sst = 6'h15;
        fb = 2; fs = 7; fst = 6'h33;
        @(negedge iclk);
        istart = 1'b1;
        iraddr_bidx = 2'(sb);
        isize_m1 = 6'(ss);
        istate = 6'(sst);
        iflush = 1'b1;
        ifraddr_bidx = 2'(fb);
        ifsize_m1 = 6'(fs);
        ifstate = 6'(fst);
        wait_accept(ok);
        if (ok) push_cmd(sb, ss, sst, 1'b0);
        @(negedge iclk);
        istart = 1'b0;
        wait_accept(ok);
        if (ok) push_cmd(fb, fs, fst, 1'b1);
        @(negedge iclk);
        iflush = 1'b0;
        wait_idle();

        // single step
        run_cmd(1'b0, 1, 0, 6'h07);
        wait_idle();

        // stretched by a random clock enable
        fill_rand();
        toggle_en = 1'b1;
        run_cmd(1'b0, 0, 63, 6'h11);
        wait_idle();
        toggle_en = 1'b0;

        // random commands
        for (int n = 0; n < 10; n++) begin
            fill_rand();
            run_cmd(1'($urandom % 2), int'($urandom % 4),
                    (n % 3 == 0) ? int'($urandom % 4) : int'($urandom % 64),
                    int'($urandom % 64));
            wait_idle();
        end

        // reset in the middle of a read burst
        fill_const(2'b01);
        run_cmd(1'b0, 1, 63, 6'h2C);
        repeat (8) @(negedge iclk);
        #2;
        ireset = 1'b1;
        #1;
        chk("mid_rst_ordy", 32'(ordy), 1);
        chk("mid_rst_oread", 32'(oread), 0);
        chk("mid_rst_oval", 32'(oval), 0);
        chk("mid_rst_osop", 32'(osop), 0);
        chk("mid_rst_oeop", 32'(oeop), 0);
        chk("mid_rst_oflush", 32'(oflush), 0);
        chk("mid_rst_oraddr", 32'(oraddr), 0);
        chk("mid_rst_obits", 32'(obits), 0);
        chk("mid_rst_ostate", 32'(ostate), 0);
        exp_q.delete();
        addr_q.delete();
        busy_q.delete();
        busy_cnt = 0;
        repeat (2) @(negedge iclk);
        ireset = 1'b0;
        repeat (20) @(negedge iclk);
        chk("post_rst_ordy", 32'(ordy), 1);

        // engine recovers
        fill_rand();
        run_cmd(1'b1, 2, 17, 6'h3A);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcm_dec_trb_engine.md
Name: tcm_dec_trb_engine

Overview:
- Traceback engine for the 4D-8PSK TCM Viterbi decoder; the reader side of the traceback decision RAM.
- Accepts regular-traceback and flush commands from the traceback controller, then walks one RAM buffer backwards from a given initial state.
- Emits decoded input bits in reverse time order, tagged with sop/eop/flush; a downstream LIFO restores time order.
- Drives the controller's engine-ready input.

Parameters:
pSTATE_W, 6, trellis state width (64 states)
pDEC_W, 2, decision bits per state (predecessor select; also decoded bits per step)
pTRB_LENGTH, 64, buffer length in trellis steps
pADDR_W, 6, in-buffer address width, log2(pTRB_LENGTH)
pBIDX_W, 2, buffer index width
pRAM_LAT, 2, RAM read latency in enabled clocks (>=1)

Ports:
iclk  in  1  clock
ireset  in  1  reset
iclkena  in  1  clock enable; all sequential logic and the read pipeline advance only when high
istart  in  1  regular traceback request, level, held until accepted
iraddr_bidx  in  pBIDX_W  buffer index for start
isize_m1  in  pADDR_W  start steps minus 1 (first read address)
istate  in  pSTATE_W  start initial state
iflush  in  1  flush request, level, held until accepted
ifraddr_bidx  in  pBIDX_W  buffer index for flush
ifsize_m1  in  pADDR_W  flush steps minus 1
ifstate  in  pSTATE_W  flush initial state
ordy  out  1  engine idle, can accept a command
oread  out  1  RAM read strobe
oraddr  out  pBIDX_W+pADDR_W  {bidx, addr} read address
irdecision  in  2**pSTATE_W*pDEC_W  RAM data, state s at bits [s*pDEC_W +: pDEC_W], valid pRAM_LAT enabled clocks after oread
oval  out  1  decoded output valid
osop  out  1  first output of a command
oeop  out  1  last output of a command
oflush  out  1  output belongs to a flush command
obits  out  pDEC_W  decoded bits
ostate  out  pSTATE_W  current traceback state (debug)

Behaviour:
- Reset: ireset asynchronous, active-high; clock iclk. Reset values: FSM=IDLE, ordy=1, oread=0, oval=0, osop=0, oeop=0, oflush=0, oraddr=0, obits=0, ostate=0.
- FSM states: IDLE, READ, DRAIN.
- ordy = (FSM==IDLE), registered.
- Acceptance, in IDLE with iclkena:
  - istart=1: latch iraddr_bidx/isize_m1/istate, flush_tag=0, go to READ.
  - else iflush=1: latch the flush fields, flush_tag=1, go to READ.
  - Start has priority when both are asserted. Inputs are ignored outside IDLE.
- READ:
  - oread=1 with addr counting down from size_m1 to 0, one per enabled clock.
  - The cycle issuing addr 0 moves to DRAIN.
  - Address sequence is data-independent, so reads are fully pipelined: throughput 1 step/clock.
- Data path, per returned word (a read-valid shift line of depth pRAM_LAT tracks sop/eop/flush):
  - obits <= cur[pSTATE_W-1 -: pDEC_W]
  - d = irdecision[cur*pDEC_W +: pDEC_W]
  - cur <= {cur[pSTATE_W-pDEC_W-1:0], d}
  - cur loads the latched initial state at acceptance.
- Output timing:
  - Command accepted at enabled edge T: oread high T+1 .. T+1+size_m1.
  - oval high T+2+pRAM_LAT .. T+2+pRAM_LAT+size_m1.
  - osop with the first oval, oeop with the last; both on the same cycle when size_m1=0.
- DRAIN: wait until the eop output is produced; then FSM=IDLE and ordy=1 on the next enabled edge.
- Busy time: ordy low for size_m1+2+pRAM_LAT enabled clocks per command.
- Back-to-back commands: gap of at least 1 clock between the last oval of one command and the first oval of the next.
- iclkena=0: all state, outputs and the read pipeline hold.
- Mid-operation reset: the in-flight command is dropped, and no oval is asserted after reset until a new command is accepted.
- bidx is not modified by the engine; wrap-around of the buffer index is the controller's responsibility.

Test Plan:
- All-zero decisions, istart, size_m1=63, istate=0, bidx=1 -> oraddr 0x7F..0x40 descending; 64 oval with obits=0; osop on first, oeop on 64th, oflush=0; ordy low 67 clocks.
- istate=0x2A, decisions all 2'b11 -> obits sequence 2'b10, 2'b10, 2'b10, then 2'b11 thereafter; ostate 0x2A→0x2B→0x2F→0x3F→0x3F.
- iflush, ifsize_m1=5, ifstate=0x3F, decisions 0 -> 6 oval; obits 3,3,3,0,0,0; oflush=1; osop/oeop on 1st/6th.
- istart and iflush asserted together -> start runs first (oflush=0); flush is accepted the clock ordy returns and completes with oflush=1.
- size_m1=0 -> single oval with osop=oeop=1.
- iclkena toggled 50% during a 64-step start -> identical output sequence stretched.
- ireset mid-READ -> outputs at reset values, ordy=1, no stray oval.
